project_mux_ctrl: RTL and testbench

PROJECT_MUX_CTRL -- requirements
Module: project_mux_ctrl

---
 rtl/project_mux_ctrl_pkg.sv | 18 +
 rtl/project_mux_ctrl_if.sv | 24 ++
 rtl/project_mux_ctrl_wdog.sv | 34 +++
 rtl/project_mux_ctrl.sv | 155 +++++++++++++++
 tb/tb_project_mux_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/project_mux_ctrl_pkg.sv
// Types and constants shared by the project bus/pad multiplexer, its
// watchdog and the host-side bus interface.
package proj_mux_pkg;

  localparam int unsigned DAT_W = 32;
  localparam int unsigned IRQ_W = 3;
  localparam int unsigned PAD_W = 38;

  localparam logic [DAT_W-1:0] ERR_DATA = 32'hBADC0DE5;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RUN,
    ST_DRAIN,
    ST_GAP
  } state_e;

endpackage

// File: rtl/project_mux_ctrl_if.sv
// Host-side wishbone slave signals shared between the host and the mux.
interface project_mux_ctrl_if;
  import proj_mux_pkg::*;

  logic             wbs_cyc_i;
  logic             wbs_stb_i;
  logic             wbs_ack_o;
  logic [DAT_W-1:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i,
    output wbs_stb_i,
    input  wbs_ack_o,
    input  wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i,
    input  wbs_stb_i,
    output wbs_ack_o,
    output wbs_dat_o
  );

endinterface

// File: rtl/project_mux_ctrl_wdog.sv
// Wishbone stall watchdog: counts strobed cycles without an ack and forces
// a one-cycle error response once the count reaches TIMEOUT.
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cyc_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic err_o
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic          expired;

  assign expired = (cnt_q == CW'(TIMEOUT));

  // A genuine ack in the expiry cycle takes priority over the forced error.
  assign err_o = ~rst_i & cyc_i & stb_i & expired & ~ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!cyc_i || ack_i || err_o) begin
      cnt_q <= '0;
    end else if (stb_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/project_mux_ctrl.sv
// Selects one of NPROJ user projects onto the host wishbone bus, IRQs and
// pads, with a drain/gap sequence on every switch and a stall watchdog.
module project_mux_ctrl
  import proj_mux_pkg::*;
#(
  parameter int unsigned NPROJ   = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned GAP     = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  project_mux_ctrl_if.slave      wb,
  input  logic [NPROJ-1:0]       sel_req,
  input  logic [NPROJ-1:0]       p_ack,
  input  logic [NPROJ*DAT_W-1:0] p_dat,
  input  logic [NPROJ*IRQ_W-1:0] p_irq,
  input  logic [NPROJ*PAD_W-1:0] p_io_out,
  input  logic [NPROJ*PAD_W-1:0] p_io_oeb,
  output logic [NPROJ-1:0]       active,
  output logic [IRQ_W-1:0]       user_irq,
  output logic [PAD_W-1:0]       io_out,
  output logic [PAD_W-1:0]       io_oeb,
  output logic                   timeout_o
);

  localparam int unsigned IW = (NPROJ > 1) ? $clog2(NPROJ) : 1;
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  function automatic logic [NPROJ-1:0] to_onehot(input logic [IW-1:0] idx);
    logic [NPROJ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  state_e           state_q;
  logic [IW-1:0]    cur_q;
  logic [NPROJ-1:0] active_q;
  logic [GW-1:0]    gap_cnt_q;

  logic             sel_valid;
  logic [IW-1:0]    sel_idx;
  int unsigned      sel_ones;
  logic [NPROJ-1:0] cur_oh;
  logic             gap_done;

  always_comb begin
    sel_ones = 0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < NPROJ; i++) begin
      if (sel_req[i]) begin
        sel_ones = sel_ones + 1;
        sel_idx  = IW'(i);
      end
    end
    sel_valid = (sel_ones == 1);
  end

  assign cur_oh   = to_onehot(cur_q);
  assign gap_done = (32'(gap_cnt_q) + 32'd1 >= GAP);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_OFF;
      cur_q     <= '0;
      active_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (sel_valid) begin
            cur_q    <= sel_idx;
            active_q <= to_onehot(sel_idx);
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (sel_req != cur_oh) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!wb.wbs_cyc_i) begin
            active_q  <= '0;
            gap_cnt_q <= '0;
            state_q   <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Only the request present on the final gap cycle is honoured.
          if (gap_done) begin
            gap_cnt_q <= '0;
            if (sel_valid) begin
              cur_q    <= sel_idx;
              active_q <= to_onehot(sel_idx);
              state_q  <= ST_RUN;
            end else begin
              state_q <= ST_OFF;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= ST_OFF;
          active_q <= '0;
        end
      endcase
    end
  end

  assign active = active_q;

  logic             proj_en;
  logic             proj_ack;
  logic [DAT_W-1:0] proj_dat;
  logic             wd_err;

  // Reset gates the selection so an in-flight access is dropped without an ack.
  assign proj_en = active_q[cur_q] & ~wb_rst_i;

  always_comb begin
    proj_ack = 1'b0;
    proj_dat = '0;
    user_irq = '0;
    io_out   = '0;
    io_oeb   = '1;
    if (proj_en) begin
      proj_ack = p_ack[cur_q];
      proj_dat = p_dat[cur_q*DAT_W +: DAT_W];
      user_irq = p_irq[cur_q*IRQ_W +: IRQ_W];
      io_out   = p_io_out[cur_q*PAD_W +: PAD_W];
      io_oeb   = p_io_oeb[cur_q*PAD_W +: PAD_W];
    end
  end

  wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .cyc_i(wb.wbs_cyc_i),
    .stb_i(wb.wbs_stb_i),
    .ack_i(proj_ack),
    .err_o(wd_err)
  );

  always_comb begin
    wb.wbs_ack_o = proj_ack | wd_err;
    wb.wbs_dat_o = wd_err ? ERR_DATA : proj_dat;
  end

  assign timeout_o = wd_err;

endmodule

// File: tb/tb_project_mux_ctrl.sv
// Directed scoreboard bench for project_mux_ctrl: selection, drain/gap
// sequencing, invalid requests, watchdog expiry and reset abandonment.
module tb_project_mux_ctrl;
  import proj_mux_pkg::*;

  localparam int unsigned NPROJ   = 2;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned GAP     = 4;
  localparam int unsigned DW2     = NPROJ * DAT_W;
  localparam int unsigned IW2     = NPROJ * IRQ_W;
  localparam int unsigned PW2     = NPROJ * PAD_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [NPROJ-1:0] sel_req;
  logic [NPROJ-1:0] p_ack;
  logic [DW2-1:0]   p_dat;
  logic [IW2-1:0]   p_irq;
  logic [PW2-1:0]   p_io_out;
  logic [PW2-1:0]   p_io_oeb;
  logic [NPROJ-1:0] active;
  logic [IRQ_W-1:0] user_irq;
  logic [PAD_W-1:0] io_out;
  logic [PAD_W-1:0] io_oeb;
  logic             timeout_o;

  project_mux_ctrl_if wb();

  project_mux_ctrl #(
    .NPROJ(NPROJ),
    .TIMEOUT(TIMEOUT),
    .GAP(GAP)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb(wb),
    .sel_req(sel_req),
    .p_ack(p_ack),
    .p_dat(p_dat),
    .p_irq(p_irq),
    .p_io_out(p_io_out),
    .p_io_oeb(p_io_oeb),
    .active(active),
    .user_irq(user_irq),
    .io_out(io_out),
    .io_oeb(io_oeb),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic push_exp(input string tag, input logic [63:0] v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h required <nothing queued>", obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
  endtask

  // One clock: drive request/cyc just after the edge, compare active mid-cycle.
  task automatic step(input logic [1:0] sel, input logic cyc,
                      input logic [1:0] exp_act, input string tag);
    @(posedge clk); #1;
    sel_req       = sel;
    wb.wbs_cyc_i  = cyc;
    push_exp(tag, 64'(exp_act));
    @(negedge clk);
    check(64'(active));
  endtask

  int          ack_cyc;
  logic [31:0] dat_seen;
  logic        to_seen;

  initial begin
    rst          = 1'b1;
    sel_req      = '0;
    p_ack        = '0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    p_dat        = {$urandom(), $urandom()};
    p_irq        = IW2'($urandom());
    p_io_out     = PW2'({$urandom(), $urandom(), $urandom()});
    p_io_oeb     = PW2'({$urandom(), $urandom(), $urandom()});

    repeat (2) @(posedge clk);
    #1;
    push_exp("rst_active", 64'd0);
    push_exp("rst_io_oeb", 64'(38'h3F_FFFF_FFFF));
    push_exp("rst_io_out", 64'd0);
    push_exp("rst_irq", 64'd0);
    push_exp("rst_ack", 64'd0);
    push_exp("rst_dat", 64'd0);
    push_exp("rst_timeout", 64'd0);
    @(negedge clk);
    check(64'(active)); check(64'(io_oeb)); check(64'(io_out)); check(64'(user_irq));
    check(64'(wb.wbs_ack_o)); check(64'(wb.wbs_dat_o)); check(64'(timeout_o));

    // Select project 0: active follows one edge later, pads/irq pass through.
    @(posedge clk); #1;
    rst     = 1'b0;
    sel_req = 2'b01;
    push_exp("sel_latency", 64'd0);
    @(negedge clk);
    check(64'(active));
    @(posedge clk); #1;
    push_exp("act_p0", 64'(2'b01));
    push_exp("io_out_p0", 64'(p_io_out[PAD_W-1:0]));
    push_exp("io_oeb_p0", 64'(p_io_oeb[PAD_W-1:0]));
    push_exp("irq_p0", 64'(p_irq[IRQ_W-1:0]));
    @(negedge clk);
    check(64'(active)); check(64'(io_out)); check(64'(io_oeb)); check(64'(user_irq));

    // Ack/data come from the selected project only, same cycle.
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    p_ack        = 2'b01;
    push_exp("ack_p0", 64'd1);
    push_exp("dat_p0", 64'(p_dat[DAT_W-1:0]));
    push_exp("to_p0", 64'd0);
    @(negedge clk);
    check(64'(wb.wbs_ack_o)); check(64'(wb.wbs_dat_o)); check(64'(timeout_o));
    @(posedge clk); #1;
    p_ack = 2'b10;
    push_exp("ack_unselected", 64'd0);
    @(negedge clk);
    check(64'(wb.wbs_ack_o));
    @(posedge clk); #1;
    p_ack        = '0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;

    // Switch to project 1 while a cycle is open; request wobbles during GAP.
    for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 2'b01, "sw_run");
    step(2'b10, 1'b1, 2'b01, "sw_req");
    for (int i = 0; i < 6; i++) step(2'b10, 1'b1, 2'b01, "sw_drain_hold");
    step(2'b10, 1'b0, 2'b01, "sw_cyc_low");
    step(2'b01, 1'b0, 2'b00, "sw_gap0");
    step(2'b11, 1'b0, 2'b00, "sw_gap1");
    step(2'b00, 1'b0, 2'b00, "sw_gap2");
    step(2'b10, 1'b0, 2'b00, "sw_gap3");
    step(2'b10, 1'b0, 2'b10, "sw_run_p1");
    push_exp("io_out_p1", 64'(p_io_out[PAD_W +: PAD_W]));
    check(64'(io_out));

    // Deselect to OFF, then an invalid multi-hot request must be ignored.
    step(2'b00, 1'b0, 2'b10, "off_req");
    step(2'b00, 1'b0, 2'b10, "off_drain");
    for (int i = 0; i < 4; i++) step(2'b00, 1'b0, 2'b00, "off_gap");
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 2'b00, "off_multihot");
    push_exp("off_io_oeb", 64'(38'h3F_FFFF_FFFF));
    check(64'(io_oeb));

    // Host access with nobody selected: forced error ack in cycle 256 only.
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    push_exp("wd_ack_cycle", 64'd256);
    push_exp("wd_err_dat", 64'(ERR_DATA));
    push_exp("wd_timeout", 64'd1);
    ack_cyc  = 0;
    dat_seen = '0;
    to_seen  = 1'b0;
    for (int k = 1; k <= 300 && ack_cyc == 0; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      if (wb.wbs_ack_o === 1'b1) begin
        ack_cyc  = k;
        dat_seen = wb.wbs_dat_o;
        to_seen  = timeout_o;
      end
    end
    check(64'(ack_cyc)); check(64'(dat_seen)); check(64'(to_seen));
    @(posedge clk); #1;
    push_exp("wd_ack_after", 64'd0);
    push_exp("wd_timeout_after", 64'd0);
    @(negedge clk);
    check(64'(wb.wbs_ack_o)); check(64'(timeout_o));
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;

    // Project ack coinciding with expiry wins over the forced error.
    step(2'b01, 1'b0, 2'b00, "race_sel");
    step(2'b01, 1'b0, 2'b01, "race_run");
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    repeat (255) begin
      @(posedge clk); #1;
    end
    p_ack = 2'b01;
    push_exp("race_ack", 64'd1);
    push_exp("race_dat", 64'(p_dat[DAT_W-1:0]));
    push_exp("race_timeout", 64'd0);
    @(negedge clk);
    check(64'(wb.wbs_ack_o)); check(64'(wb.wbs_dat_o)); check(64'(timeout_o));
    @(posedge clk); #1;
    p_ack        = '0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;

    // Reset during DRAIN abandons the access: no ack, back to OFF.
    step(2'b10, 1'b1, 2'b01, "rd_run");
    step(2'b10, 1'b1, 2'b01, "rd_drain");
    @(posedge clk); #1;
    rst          = 1'b1;
    wb.wbs_stb_i = 1'b1;
    p_ack        = 2'b01;
    push_exp("rd_ack_in_rst", 64'd0);
    @(negedge clk);
    check(64'(wb.wbs_ack_o));
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp("rd_active", 64'd0);
    push_exp("rd_state", 64'(ST_OFF));
    push_exp("rd_ack", 64'd0);
    @(negedge clk);
    check(64'(active)); check(64'(dut.state_q)); check(64'(wb.wbs_ack_o));

    @(posedge clk); #1;
    p_ack        = '0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
